// File: rtl/mem_pkg.sv
// Shared opcode encodings and FSM state type for the memory responder.
package mem_pkg;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, registered read data, storage not reset.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port and registered read of the addressed word
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: accepts one request, waits WAIT_STATES cycles, then answers.
// Optional write protection of the low PROT_WORDS words is enabled by defining MEM_WP_EN.
module memory_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1,
    parameter int PROT_WORDS  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_enable,
    input  logic              mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int       AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef MEM_WP_EN
    localparam logic WP_ON = 1'b1;
`else
    localparam logic WP_ON = 1'b0;
`endif

    mem_state_t        state_r;
    logic [3:0]        cnt_r;
    logic              op_r;
    logic [AW-1:0]     addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              fault_r;

    logic              in_range_s;
    logic              wp_hit_s;
    logic              fault_s;
    logic [AW-1:0]     ram_addr_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] ram_rdata_s;

    assign in_range_s = (mem_addr < ADDR_W'(DEPTH));
    assign wp_hit_s   = (mem_op == MEM_OP_WRITE) && (mem_addr < ADDR_W'(PROT_WORDS));
    assign fault_s    = !in_range_s || (WP_ON && wp_hit_s);

    // The RAM sees the live address while idle so read data is ready by the response edge
    assign ram_addr_s = (state_r == IDLE) ? mem_addr[AW-1:0] : addr_r;
    assign ram_we_s   = (state_r == RESP) && (op_r == MEM_OP_WRITE) && !fault_r;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem_array (
        .clock (clock),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Transaction FSM with registered handshake outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            op_r      <= MEM_OP_READ;
            addr_r    <= '0;
            wdata_r   <= '0;
            fault_r   <= 1'b0;
            mem_rdata <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_enable) begin
                        op_r     <= mem_op;
                        addr_r   <= mem_addr[AW-1:0];
                        wdata_r  <= mem_wdata;
                        fault_r  <= fault_s;
                        mem_busy <= 1'b1;
                        cnt_r    <= (WS == 4'd0) ? 4'd0 : WS - 4'd1;
                        state_r  <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b1;
                    mem_err   <= fault_r;
                    mem_busy  <= 1'b0;
                    if (op_r == MEM_OP_READ) begin
                        mem_rdata <= fault_r ? '0 : ram_rdata_s;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
